// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared digit widths, limits, seven-segment and anode patterns
`timescale 1ns/1ps
package stopwatch_pkg;

    localparam int DIGIT_W = 4;
    localparam int MAX_9   = 9;
    localparam int MAX_5   = 5;

    typedef logic [DIGIT_W-1:0] bcd_t;

    // segment order {g,f,e,d,c,b,a}, active low
    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_ERR = 7'b0111111;

    // active-low one-hot digit enables; AN_0 selects tenths, AN_3 selects minutes
    localparam logic [3:0] AN_0 = 4'b1110;
    localparam logic [3:0] AN_1 = 4'b1101;
    localparam logic [3:0] AN_2 = 4'b1011;
    localparam logic [3:0] AN_3 = 4'b0111;

    function automatic logic [6:0] seg_decode(input bcd_t d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_ERR;
        endcase
    endfunction

    function automatic logic [3:0] an_sel(input logic [1:0] i);
        return ~(4'b0001 << i);
    endfunction

endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// bcd_digit: one BCD counter stage that wraps at MAX and emits a combinational carry
`timescale 1ns/1ps
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    logic at_max;

    assign at_max = (q == DIGIT_W'(MAX));
    assign carry  = inc && at_max;

    // clear wins over increment; increment wraps to zero past MAX
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc)
            q <= at_max ? '0 : q + DIGIT_W'(1);
    end

endmodule

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: BCD elapsed-time counter 0:00.0..9:59.9 with multiplexed seven-segment drive
`timescale 1ns/1ps
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_DIV  = 10,
    parameter int SCAN_DIV = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clken,
    input  logic               rst,
    output logic [DIGIT_W-1:0] tenths,
    output logic [DIGIT_W-1:0] sec_lo,
    output logic [DIGIT_W-1:0] sec_hi,
    output logic [DIGIT_W-1:0] min,
    output logic               wrap,
    output logic [3:0]         an,
    output logic [6:0]         seg,
    output logic               dp
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] prescaler;
    logic          tick;
    logic          c_tenths, c_sec_lo, c_sec_hi, c_min;
    logic [SW-1:0] scan_cnt;
    logic          scan_step;
    logic [1:0]    idx;
    bcd_t          cur;

    assign tick      = clken && (prescaler == PW'(CLK_DIV - 1));
    assign scan_step = (scan_cnt == SW'(SCAN_DIV - 1));

    // prescaler holds while paused so a partial tenth survives a pause
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            prescaler <= '0;
        else if (rst)
            prescaler <= '0;
        else if (clken)
            prescaler <= tick ? '0 : prescaler + PW'(1);
    end

    bcd_digit #(.MAX(MAX_9)) u_tenths (
        .clk   (clk),
        .reset (reset),
        .clr   (rst),
        .inc   (tick),
        .q     (tenths),
        .carry (c_tenths)
    );

    bcd_digit #(.MAX(MAX_9)) u_sec_lo (
        .clk   (clk),
        .reset (reset),
        .clr   (rst),
        .inc   (c_tenths),
        .q     (sec_lo),
        .carry (c_sec_lo)
    );

    bcd_digit #(.MAX(MAX_5)) u_sec_hi (
        .clk   (clk),
        .reset (reset),
        .clr   (rst),
        .inc   (c_sec_lo),
        .q     (sec_hi),
        .carry (c_sec_hi)
    );

    bcd_digit #(.MAX(MAX_9)) u_min (
        .clk   (clk),
        .reset (reset),
        .clr   (rst),
        .inc   (c_sec_hi),
        .q     (min),
        .carry (c_min)
    );

    // carry out of the minute digit marks the 9:59.9 -> 0:00.0 roll-over
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wrap <= 1'b0;
        else
            wrap <= !rst && c_min;
    end

    // free-running digit scan, deliberately blind to clken and rst
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else begin
            scan_cnt <= scan_step ? '0 : scan_cnt + SW'(1);
            idx      <= idx + 2'(scan_step);
        end
    end

    // select the digit currently being scanned
    always_comb begin
        cur = (idx == 2'd0) ? tenths :
              (idx == 2'd1) ? sec_lo :
              (idx == 2'd2) ? sec_hi : min;
    end

    // registered display drive, one cycle behind the digit registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= AN_0;
            seg <= SEG_0;
            dp  <= 1'b1;
        end else begin
            an  <= an_sel(idx);
            seg <= seg_decode(cur);
            dp  <= (idx != 2'd1);
        end
    end

endmodule
